// File: rtl/prime_scanner.sv
// Scans candidates 2..limit against the sieve lookup and streams every prime found,
// then reports the prime count together with a one-cycle done pulse.
module prime_scanner #(
    parameter int LOOKUP_LAT = 1,
    parameter int W          = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] limit_i,
    input  logic         sieve_ready_i,
    output logic [W-1:0] query_addr_o,
    input  logic         query_is_prime_i,
    output logic         prime_valid_o,
    output logic [W-1:0] prime_data_o,
    input  logic         prime_ready_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] prime_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SIEVE,
        ISSUE,
        WAIT_LAT,
        EMIT,
        ADVANCE,
        FINISH
    } state_t;

    localparam logic [2:0]   LatCnt   = 3'(LOOKUP_LAT);
    localparam logic [W-1:0] CountMax = '1;
    localparam logic [W-1:0] FirstCand = W'(2);

    state_t       state_q,      state_d;
    logic [W-1:0] limit_q,      limit_d;
    logic [W-1:0] candidate_q,  candidate_d;
    logic [2:0]   waitCnt_q,    waitCnt_d;
    logic [W-1:0] queryAddr_q,  queryAddr_d;
    logic         primeValid_q, primeValid_d;
    logic [W-1:0] primeData_q,  primeData_d;
    logic [W-1:0] primeCount_q, primeCount_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            limit_q      <= '0;
            candidate_q  <= '0;
            waitCnt_q    <= '0;
            queryAddr_q  <= '0;
            primeValid_q <= 1'b0;
            primeData_q  <= '0;
            primeCount_q <= '0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            candidate_q  <= candidate_d;
            waitCnt_q    <= waitCnt_d;
            queryAddr_q  <= queryAddr_d;
            primeValid_q <= primeValid_d;
            primeData_q  <= primeData_d;
            primeCount_q <= primeCount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        candidate_d  = candidate_q;
        waitCnt_d    = waitCnt_q;
        queryAddr_d  = queryAddr_q;
        primeValid_d = primeValid_q;
        primeData_d  = primeData_q;
        primeCount_d = primeCount_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    limit_d      = limit_i;
                    primeCount_d = '0;
                    candidate_d  = FirstCand;
                    state_d      = WAIT_SIEVE;
                end
            end

            // An empty range finishes even if the sieve never becomes ready.
            WAIT_SIEVE: begin
                if (limit_q < FirstCand) begin
                    state_d = FINISH;
                end else if (sieve_ready_i) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                queryAddr_d = candidate_q;
                waitCnt_d   = '0;
                state_d     = WAIT_LAT;
            end

            WAIT_LAT: begin
                waitCnt_d = waitCnt_q + 3'd1;
                if (waitCnt_q + 3'd1 == LatCnt) begin
                    if (query_is_prime_i) begin
                        primeData_d  = candidate_q;
                        primeValid_d = 1'b1;
                        state_d      = EMIT;
                    end else begin
                        state_d = ADVANCE;
                    end
                end
            end

            EMIT: begin
                if (primeValid_q && prime_ready_i) begin
                    primeValid_d = 1'b0;
                    if (primeCount_q != CountMax) begin
                        primeCount_d = primeCount_q + W'(1);
                    end
                    state_d = ADVANCE;
                end
            end

            // Compare before incrementing so a limit of 255 never wraps the candidate.
            ADVANCE: begin
                if (candidate_q == limit_q) begin
                    state_d = FINISH;
                end else begin
                    candidate_d = candidate_q + W'(1);
                    state_d     = ISSUE;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign query_addr_o  = queryAddr_q;
    assign prime_valid_o = primeValid_q;
    assign prime_data_o  = primeData_q;
    assign prime_count_o = primeCount_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FINISH);

endmodule

// File: tb/tb_prime_scanner.sv
// Drives a LAT=1 and a LAT=3 scanner side by side against a behavioural sieve and
// a trial-division prime list, with randomized downstream backpressure.
module tb_prime_scanner;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN;
    logic         start;
    logic [W-1:0] limit;
    logic         sieveReady;
    logic         ready1, ready3;

    logic [W-1:0] qa1, qa3, pd1, pd3, pc1, pc3;
    logic         pv1, pv3, busy1, busy3, done1, done3;
    logic         isPrime1, isPrime3;
    logic         lat3Stage1, lat3Stage2;

    int nChecks = 0;
    int nErrors = 0;

    logic [W-1:0] got1[$];
    logic [W-1:0] got3[$];
    logic [W-1:0] expQ[$];
    int           doneCnt1 = 0;
    int           doneCnt3 = 0;
    logic         stall1 = 1'b0, stall3 = 1'b0;
    logic [W-1:0] held1 = '0, held3 = '0;

    prime_scanner #(.LOOKUP_LAT(1), .W(W)) u_dut1 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .limit_i(limit),
        .sieve_ready_i(sieveReady), .query_addr_o(qa1), .query_is_prime_i(isPrime1),
        .prime_valid_o(pv1), .prime_data_o(pd1), .prime_ready_i(ready1),
        .busy_o(busy1), .done_o(done1), .prime_count_o(pc1)
    );

    prime_scanner #(.LOOKUP_LAT(3), .W(W)) u_dut3 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .limit_i(limit),
        .sieve_ready_i(sieveReady), .query_addr_o(qa3), .query_is_prime_i(isPrime3),
        .prime_valid_o(pv3), .prime_data_o(pd3), .prime_ready_i(ready3),
        .busy_o(busy3), .done_o(done3), .prime_count_o(pc3)
    );

    function automatic bit refIsPrime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Sieve lookup: combinational for LAT=1, two register stages for LAT=3, so an
    // early sample of the LAT=3 result sees the previous address's answer.
    always_comb isPrime1 = refIsPrime(int'(qa1));

    always @(posedge clk) begin
        lat3Stage1 <= refIsPrime(int'(qa3));
        lat3Stage2 <= lat3Stage1;
    end
    assign isPrime3 = lat3Stage2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Stream monitors: record handshakes, count done pulses, and require data held under stall.
    always @(negedge clk) begin
        if (rstN) begin
            if (stall1) begin
                checkOutput("hold1.valid", 32'(pv1), 32'd1);
                checkOutput("hold1.data", 32'(pd1), 32'(held1));
            end
            if (pv1 && ready1) got1.push_back(pd1);
            if (done1) doneCnt1++;
            stall1 = pv1 && !ready1;
            held1  = pd1;
        end else begin
            stall1 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            if (stall3) begin
                checkOutput("hold3.valid", 32'(pv3), 32'd1);
                checkOutput("hold3.data", 32'(pd3), 32'(held3));
            end
            if (pv3 && ready3) got3.push_back(pd3);
            if (done3) doneCnt3++;
            stall3 = pv3 && !ready3;
            held3  = pd3;
        end else begin
            stall3 = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic buildModel(input int lim);
        expQ.delete();
        for (int n = 2; n <= lim; n++) begin
            if (refIsPrime(n)) expQ.push_back(W'(n));
        end
    endtask

    task automatic checkIdle(input string pre);
        checkOutput({pre, ".qa1"},    32'(qa1),   32'd0);
        checkOutput({pre, ".qa3"},    32'(qa3),   32'd0);
        checkOutput({pre, ".pv1"},    32'(pv1),   32'd0);
        checkOutput({pre, ".pv3"},    32'(pv3),   32'd0);
        checkOutput({pre, ".pd1"},    32'(pd1),   32'd0);
        checkOutput({pre, ".pd3"},    32'(pd3),   32'd0);
        checkOutput({pre, ".busy1"},  32'(busy1), 32'd0);
        checkOutput({pre, ".busy3"},  32'(busy3), 32'd0);
        checkOutput({pre, ".done1"},  32'(done1), 32'd0);
        checkOutput({pre, ".done3"},  32'(done3), 32'd0);
        checkOutput({pre, ".count1"}, 32'(pc1),   32'd0);
        checkOutput({pre, ".count3"}, 32'(pc3),   32'd0);
    endtask

    task automatic applyStimulus(input int lim);
        got1.delete();
        got3.delete();
        doneCnt1 = 0;
        doneCnt3 = 0;
        limit = W'(lim);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit randRdy);
        int n = 0;
        while (!(doneCnt1 > 0 && doneCnt3 > 0) && n < budget) begin
            tick();
            if (randRdy) begin
                ready1 = 1'($urandom_range(0, 1));
                ready3 = 1'($urandom_range(0, 1));
            end
            n++;
        end
        checkOutput("waitDone.inTime", 32'(doneCnt1 > 0 && doneCnt3 > 0), 32'd1);
        ready1 = 1'b1;
        ready3 = 1'b1;
    endtask

    task automatic checkScan(input string pre, input int lim);
        repeat (3) tick();
        buildModel(lim);
        checkOutput({pre, ".n1"}, 32'(got1.size()), 32'(expQ.size()));
        checkOutput({pre, ".n3"}, 32'(got3.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < got1.size()) checkOutput({pre, ".prime1"}, 32'(got1[i]), 32'(expQ[i]));
            if (i < got3.size()) checkOutput({pre, ".prime3"}, 32'(got3[i]), 32'(expQ[i]));
        end
        checkOutput({pre, ".count1"}, 32'(pc1),      32'(expQ.size()));
        checkOutput({pre, ".count3"}, 32'(pc3),      32'(expQ.size()));
        checkOutput({pre, ".dones1"}, 32'(doneCnt1), 32'd1);
        checkOutput({pre, ".dones3"}, 32'(doneCnt3), 32'd1);
        checkOutput({pre, ".busy1"},  32'(busy1),    32'd0);
        checkOutput({pre, ".busy3"},  32'(busy3),    32'd0);
    endtask

    task automatic checkEmptyScan(input string pre, input int lim);
        applyStimulus(lim);
        checkOutput({pre, ".earlyDone1"}, 32'(done1), 32'd0);
        checkOutput({pre, ".earlyDone3"}, 32'(done3), 32'd0);
        tick();
        checkOutput({pre, ".done1"}, 32'(done1), 32'd1);
        checkOutput({pre, ".done3"}, 32'(done3), 32'd1);
        checkOutput({pre, ".busyFin1"}, 32'(busy1), 32'd1);
        tick();
        checkIdle(pre);
        checkOutput({pre, ".dones1"}, 32'(doneCnt1), 32'd1);
        checkOutput({pre, ".dones3"}, 32'(doneCnt3), 32'd1);
        checkOutput({pre, ".streamed1"}, 32'(got1.size()), 32'd0);
        checkOutput({pre, ".streamed3"}, 32'(got3.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] qaHold1, qaHold3;
        int stallN;
        int n;

        rstN       = 1'b0;
        start      = 1'b0;
        limit      = '0;
        sieveReady = 1'b1;
        ready1     = 1'b1;
        ready3     = 1'b1;
        repeat (3) tick();
        checkIdle("reset");
        rstN = 1'b1;
        tick();

        checkEmptyScan("limit1", 1);
        checkEmptyScan("limit0", 0);

        applyStimulus(10);
        waitDone(500, 1'b0);
        checkScan("limit10", 10);

        applyStimulus(255);
        waitDone(4000, 1'b1);
        checkScan("limit255", 255);

        // Hold off the LAT=1 consumer for exactly five cycles while 3 is offered.
        applyStimulus(20);
        stallN = 0;
        n = 0;
        while (!(doneCnt1 > 0 && doneCnt3 > 0) && n < 1000) begin
            tick();
            if (pv1 && pd1 == W'(3) && stallN < 5) begin
                ready1 = 1'b0;
                stallN++;
            end else begin
                ready1 = 1'b1;
            end
            ready3 = 1'($urandom_range(0, 1));
            n++;
        end
        ready1 = 1'b1;
        ready3 = 1'b1;
        checkOutput("stall.cycles", 32'(stallN), 32'd5);
        checkScan("limit20", 20);

        // Sieve not ready: scanner parks with busy high and the lookup address untouched.
        sieveReady = 1'b0;
        qaHold1 = qa1;
        qaHold3 = qa3;
        applyStimulus(7);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("sieveWait.qa1",   32'(qa1),   32'(qaHold1));
            checkOutput("sieveWait.qa3",   32'(qa3),   32'(qaHold3));
            checkOutput("sieveWait.busy1", 32'(busy1), 32'd1);
            checkOutput("sieveWait.busy3", 32'(busy3), 32'd1);
        end
        sieveReady = 1'b1;
        repeat (6) tick();
        limit = W'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(500, 1'b1);
        checkScan("midStart", 7);

        // Reset while the LAT=3 scanner offers 7.
        applyStimulus(13);
        n = 0;
        while (!(pv3 && pd3 == W'(7)) && n < 300) begin
            tick();
            n++;
        end
        checkOutput("rst.offer7", 32'(pv3 && pd3 == W'(7)), 32'd1);
        rstN = 1'b0;
        #1;
        checkIdle("rstAsync");
        repeat (2) tick();
        rstN = 1'b1;
        repeat (3) tick();
        checkOutput("rst.noDone1", 32'(doneCnt1), 32'd0);
        checkOutput("rst.noDone3", 32'(doneCnt3), 32'd0);
        checkIdle("rstAfter");

        applyStimulus(13);
        waitDone(800, 1'b1);
        checkScan("afterRst13", 13);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/prime_scanner.md
Name: prime_scanner

Overview:
- Downstream consumer of the sieve lookup stage.
- Given an upper bound, walks every candidate 2..limit and queries the sieve lookup (address out, is-prime flag back after a fixed latency).
- Emits each prime found as a valid/ready stream, then reports the total prime count and a done pulse.
- Feeds display/UART formatting logic further down the chain.

Parameters:
- LOOKUP_LAT, 1, clock cycles from a query_addr change to a valid query_is_prime; legal range 1..4.
- W, 8, width of candidate, limit and count; fixed at 8 for the 256-entry sieve.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- limit  in  W  inclusive upper bound; latched on an accepted start.
- sieve_ready  in  1  high when the sieve table is built and the lookup is valid.
- query_addr  out  W  candidate presented to the sieve lookup; registered.
- query_is_prime  in  1  lookup result for query_addr, valid LOOKUP_LAT cycles after query_addr changes.
- prime_valid  out  1  stream valid.
- prime_data  out  W  prime value; stable while prime_valid=1 and prime_ready=0.
- prime_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at scan end.
- prime_count  out  W  primes emitted in the current/last scan; holds until the next accepted start.

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE; query_addr=0, prime_valid=0, prime_data=0, busy=0, done=0, prime_count=0; latched limit=0, candidate=0, wait counter=0.
- IDLE:
  - On start=1: latch limit, clear prime_count, set candidate=2, go to WAIT_SIEVE.
  - start is ignored in all other states.
- WAIT_SIEVE:
  - If latched limit<2, go to FINISH; this check takes precedence over sieve_ready.
  - Otherwise, when sieve_ready=1, go to ISSUE.
- ISSUE: load query_addr=candidate, clear wait counter, go to WAIT_LAT.
- WAIT_LAT:
  - Increment wait counter each cycle.
  - Sample query_is_prime in the cycle where the counter reaches LOOKUP_LAT. With LAT=1, query_addr is stable for 1 cycle before sampling.
  - Sampled 1: load prime_data=candidate, assert prime_valid, go to EMIT.
  - Sampled 0: go to ADVANCE.
- EMIT:
  - Hold prime_valid/prime_data until the prime_valid&prime_ready handshake.
  - On the handshake cycle: deassert prime_valid next cycle, prime_count+1, go to ADVANCE.
  - prime_valid never deasserts without a handshake.
- ADVANCE:
  - If candidate==latched limit, go to FINISH.
  - Else candidate+1, go to ISSUE.
  - Compare before increment so limit=255 never wraps candidate to 0.
- FINISH: assert done for exactly one cycle, go to IDLE.
  - busy drops in the same cycle IDLE is entered.
  - start on the cycle after done is accepted.
- Arithmetic:
  - prime_count saturates at 255; this is never reached, since the maximum is 54 for limit=255.
  - query_addr is only loaded in ISSUE and otherwise holds its value.
- sieve_ready:
  - sieve_ready dropping after WAIT_SIEVE is not rechecked.
  - The sieve is not rebuilt mid-scan; upstream guarantees this.
- Reset mid-scan: all state cleared immediately.
  - Any in-flight prime_valid is dropped.
  - No done pulse is produced.
- Throughput: one candidate per (2+LOOKUP_LAT) cycles plus stall time in EMIT.

Test Plan:
- LAT=1, sieve_ready=1, limit=10, prime_ready=1 -> stream 2,3,5,7 in order; done pulses once; prime_count=4; busy low after done.
- limit=1 (and separately limit=0) -> no prime_valid; done pulses 2 cycles after start (WAIT_SIEVE→FINISH); prime_count=0; query_addr stays 0.
- limit=255, prime_ready=1 -> 54 primes, last prime_data=251; candidate never wraps; prime_count=54; exactly one done.
- limit=20, prime_ready low for 5 cycles while prime_data=3 is offered -> prime_valid=1 and prime_data=3 held stable all 5 cycles; no duplicate 3; count ends 8.
- start with sieve_ready=0 for 10 cycles, limit=7 -> query_addr unchanged, busy=1; after sieve_ready rises, primes 2,3,5,7 appear; a second start pulsed mid-scan is ignored (count ends 4, not reset).
- LAT=3, limit=13; rst_n pulsed low while prime_data=7 is valid -> outputs 0 asynchronously, no done; a new start with limit=13 yields 2,3,5,7,11,13 with count 6.
